cic_decim_comb_mc: RTL

- Multi-channel, multi-stage comb section for the CIC decimator. It sits after the decimation strobe and before the compensation FIR.
- Accepts time-interleaved complex (I/Q) samples tagged with a channel index.
- Applies NUM_STAGES cascaded comb stages (y = x - x[n-D]) with independent history per channel.
- Runtime-selectable differential delay; output rounded/saturated to OUT_WIDTH.

---
 rtl/cic_decim_comb_mc_pkg.sv | 33 +++
 rtl/cic_decim_comb_mc_if.sv | 36 +++
 rtl/cic_comb_stage_mc.sv | 95 +++++++++
 rtl/cic_decim_comb_mc.sv | 102 ++++++++++
 4 files changed

// File: rtl/cic_decim_comb_mc_pkg.sv
// Shared types and elaboration helpers for the multi-channel CIC comb section.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cic_pkg;

    // Reference sample layout at the default width; modules re-declare the same
    // {inph, quad} layout at their own WIDTH.
    localparam int IQ_W = 16;

    typedef struct packed {
        logic [IQ_W-1:0] inph;
        logic [IQ_W-1:0] quad;
    } iq_sample_t;

    function automatic int ch_w(input int num_channels);
        return (num_channels > 1) ? $clog2(num_channels) : 1;
    endfunction

    function automatic int dly_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Select 0 means D=1; selects above max_delay clamp to max_delay.
    function automatic int eff_delay(input int sel, input int max_delay);
        if (sel == 0) begin
            return 1;
        end else if (sel > max_delay) begin
            return max_delay;
        end
        return sel;
    endfunction

endpackage

// File: rtl/cic_decim_comb_mc_if.sv
// Sample bus into and out of the comb section, plus delay select and flush.
// Latency: n/a (wiring only).
// Backpressure: none; valid-only qualification in both directions.
interface cic_decim_comb_mc_if
    import cic_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_DELAY    = 2
);
    localparam int CH_W  = ch_w(NUM_CHANNELS);
    localparam int DLY_W = dly_w(MAX_DELAY);

    logic [WIDTH-1:0]     i_inph_data;
    logic [WIDTH-1:0]     i_quad_data;
    logic [CH_W-1:0]      i_channel;
    logic                 i_valid;
    logic [DLY_W-1:0]     i_delay;
    logic                 i_flush;
    logic [OUT_WIDTH-1:0] o_inph_data;
    logic [OUT_WIDTH-1:0] o_quad_data;
    logic [CH_W-1:0]      o_channel;
    logic                 o_valid;

    modport master (
        output i_inph_data, i_quad_data, i_channel, i_valid, i_delay, i_flush,
        input  o_inph_data, o_quad_data, o_channel, o_valid
    );

    modport slave (
        input  i_inph_data, i_quad_data, i_channel, i_valid, i_delay, i_flush,
        output o_inph_data, o_quad_data, o_channel, o_valid
    );

endinterface

// File: rtl/cic_comb_stage_mc.sv
// One comb stage y = x - x[n-D] with an independent delay line per channel.
// Latency: 1 cycle.
// Backpressure: none; out-of-range channels and flush-cycle samples are dropped.
module cic_comb_stage_mc
    import cic_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_DELAY    = 2,
    parameter int CH_W         = ch_w(NUM_CHANNELS),
    parameter int DLY_W        = dly_w(MAX_DELAY)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic [DLY_W-1:0] i_delay,
    input  logic [WIDTH-1:0] i_inph,
    input  logic [WIDTH-1:0] i_quad,
    input  logic [CH_W-1:0]  i_channel,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_inph,
    output logic [WIDTH-1:0] o_quad,
    output logic [CH_W-1:0]  o_channel,
    output logic             o_valid
);
    logic [WIDTH-1:0] hist_inph_q [NUM_CHANNELS][MAX_DELAY];
    logic [WIDTH-1:0] hist_inph_d [NUM_CHANNELS][MAX_DELAY];
    logic [WIDTH-1:0] hist_quad_q [NUM_CHANNELS][MAX_DELAY];
    logic [WIDTH-1:0] hist_quad_d [NUM_CHANNELS][MAX_DELAY];
    logic [WIDTH-1:0] inph_q, inph_d;
    logic [WIDTH-1:0] quad_q, quad_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic             vld_q, vld_d;
    int               ch_idx;
    int               tap;

    always_comb begin
        hist_inph_d = hist_inph_q;
        hist_quad_d = hist_quad_q;
        inph_d      = inph_q;
        quad_d      = quad_q;
        chan_d      = chan_q;
        vld_d       = 1'b0;
        ch_idx      = int'(i_channel);
        tap         = eff_delay(int'(i_delay), MAX_DELAY) - 1;
        if (i_flush) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < MAX_DELAY; k++) begin
                    hist_inph_d[c][k] = '0;
                    hist_quad_d[c][k] = '0;
                end
            end
        end else if (i_valid && (ch_idx < NUM_CHANNELS)) begin
            // Modulo-2^WIDTH difference: wrap-around is what keeps the CIC exact.
            inph_d = i_inph - hist_inph_q[ch_idx][tap];
            quad_d = i_quad - hist_quad_q[ch_idx][tap];
            for (int k = MAX_DELAY - 1; k > 0; k--) begin
                hist_inph_d[ch_idx][k] = hist_inph_q[ch_idx][k-1];
                hist_quad_d[ch_idx][k] = hist_quad_q[ch_idx][k-1];
            end
            hist_inph_d[ch_idx][0] = i_inph;
            hist_quad_d[ch_idx][0] = i_quad;
            chan_d = i_channel;
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < MAX_DELAY; k++) begin
                    hist_inph_q[c][k] <= '0;
                    hist_quad_q[c][k] <= '0;
                end
            end
            inph_q <= '0;
            quad_q <= '0;
            chan_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            hist_inph_q <= hist_inph_d;
            hist_quad_q <= hist_quad_d;
            inph_q      <= inph_d;
            quad_q      <= quad_d;
            chan_q      <= chan_d;
            vld_q       <= vld_d;
        end
    end

    assign o_inph    = inph_q;
    assign o_quad    = quad_q;
    assign o_channel = chan_q;
    assign o_valid   = vld_q;

endmodule

// File: rtl/cic_decim_comb_mc.sv
// Multi-channel CIC comb cascade with rounding/saturating output register.
// Latency: NUM_STAGES+1 cycles from i_valid to o_valid.
// Backpressure: none; one sample per cycle, flush drops everything in flight.
module cic_decim_comb_mc
    import cic_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int OUT_WIDTH    = 16,
    parameter int NUM_STAGES   = 3,
    parameter int NUM_CHANNELS = 4,
    parameter int MAX_DELAY    = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    cic_decim_comb_mc_if.slave  bus
);
    localparam int CH_W  = ch_w(NUM_CHANNELS);
    localparam int DLY_W = dly_w(MAX_DELAY);
    localparam int RSH   = (OUT_WIDTH < WIDTH) ? (WIDTH - OUT_WIDTH - 1) : 0;
    localparam logic [WIDTH:0] HALF = (OUT_WIDTH < WIDTH) ? ((WIDTH+1)'(1) << RSH) : '0;

    logic [WIDTH-1:0] st_inph [NUM_STAGES+1];
    logic [WIDTH-1:0] st_quad [NUM_STAGES+1];
    logic [CH_W-1:0]  st_chan [NUM_STAGES+1];
    logic             st_vld  [NUM_STAGES+1];

    logic [OUT_WIDTH-1:0] out_inph_q, out_inph_d;
    logic [OUT_WIDTH-1:0] out_quad_q, out_quad_d;
    logic [CH_W-1:0]      out_chan_q, out_chan_d;
    logic                 out_vld_q, out_vld_d;

    assign st_inph[0] = bus.i_inph_data;
    assign st_quad[0] = bus.i_quad_data;
    assign st_chan[0] = bus.i_channel;
    assign st_vld[0]  = bus.i_valid;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        cic_comb_stage_mc #(
            .WIDTH        (WIDTH),
            .NUM_CHANNELS (NUM_CHANNELS),
            .MAX_DELAY    (MAX_DELAY),
            .CH_W         (CH_W),
            .DLY_W        (DLY_W)
        ) u_stage (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_flush   (bus.i_flush),
            .i_delay   (bus.i_delay),
            .i_inph    (st_inph[s]),
            .i_quad    (st_quad[s]),
            .i_channel (st_chan[s]),
            .i_valid   (st_vld[s]),
            .o_inph    (st_inph[s+1]),
            .o_quad    (st_quad[s+1]),
            .o_channel (st_chan[s+1]),
            .o_valid   (st_vld[s+1])
        );
    end

    // Sign-extend by one bit so a carry into the sign marks positive overflow.
    function automatic logic [OUT_WIDTH-1:0] round_sat(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] sum;
        sum = {x[WIDTH-1], x} + HALF;
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            return ~(OUT_WIDTH'(1) << (OUT_WIDTH - 1));
        end
        return sum[WIDTH-1 -: OUT_WIDTH];
    endfunction

    always_comb begin
        out_inph_d = out_inph_q;
        out_quad_d = out_quad_q;
        out_chan_d = out_chan_q;
        out_vld_d  = 1'b0;
        if (st_vld[NUM_STAGES] && !bus.i_flush) begin
            out_inph_d = round_sat(st_inph[NUM_STAGES]);
            out_quad_d = round_sat(st_quad[NUM_STAGES]);
            out_chan_d = st_chan[NUM_STAGES];
            out_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            out_inph_q <= '0;
            out_quad_q <= '0;
            out_chan_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            out_inph_q <= out_inph_d;
            out_quad_q <= out_quad_d;
            out_chan_q <= out_chan_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign bus.o_inph_data = out_inph_q;
    assign bus.o_quad_data = out_quad_q;
    assign bus.o_channel   = out_chan_q;
    assign bus.o_valid     = out_vld_q;

endmodule
